// File: rtl/dbns_pkg.sv
// Shared definitions for the DBNS-to-binary converter.
// Holds the term count, the per-term weight table (2^A * 3^BC for digit
// storeABC), default field widths, index sizing and the FSM state type.
package dbns_pkg;

  localparam int NUM_TERMS   = 6;
  localparam int STORE_W_DEF = 4;
  localparam int OUT_W_DEF   = 10;   // 15 * (1+3+9+2+6+18) = 585 < 1024
  localparam int IDX_W       = 3;
  localparam int WEIGHT_W    = 5;    // largest weight is 18

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);

  typedef logic [WEIGHT_W-1:0] weight_t;

  // Term order 000, 001, 010, 100, 101, 110.
  localparam weight_t WEIGHTS [NUM_TERMS] = '{5'd1, 5'd3, 5'd9, 5'd2, 5'd6, 5'd18};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/dbns_term_mult.sv
// Combinational digit * weight for one DBNS term.
// Each term product is a sum of shifted copies of the digit, one per set bit
// of that term's constant weight, so only adders are built; idx_i then
// selects which of the six products appears on product_o.
//
// Ports:
//   idx_i      term index 0..5 (other codes give 0)
//   digit_i    digit count for the selected term
//   product_o  digit * weight[idx_i], zero-extended to OUT_W
module dbns_term_mult
  import dbns_pkg::*;
#(
  parameter int STORE_W = STORE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [STORE_W-1:0] digit_i,
  output logic [OUT_W-1:0]   product_o
);

  logic [OUT_W-1:0] digit_ext;
  logic [OUT_W-1:0] term_prod [NUM_TERMS];

  assign digit_ext = OUT_W'(digit_i);

  // Weight bits are constants, so each inner 'if' collapses at elaboration.
  always_comb begin
    for (int k = 0; k < NUM_TERMS; k++) begin
      term_prod[k] = '0;
      for (int b = 0; b < WEIGHT_W; b++) begin
        if (WEIGHTS[k][b]) begin
          term_prod[k] = term_prod[k] + (digit_ext << b);
        end
      end
    end
  end

  always_comb begin
    product_o = '0;
    for (int k = 0; k < NUM_TERMS; k++) begin
      if (idx_i == IDX_W'(k)) begin
        product_o = term_prod[k];
      end
    end
  end

endmodule

// File: rtl/dbns_to_binary.sv
// Converts a six-digit DBNS operand bundle to an unsigned binary value.
// A bundle is captured in IDLE, one weighted term is accumulated per cycle in
// ACCUM (six cycles), and the result is offered in DONE until accepted.
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   bundle handshake (in_ready only in IDLE)
//   store000..store110    digit counts, weights 1, 3, 9, 2, 6, 18
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   out_value             converted value, 0 whenever out_valid is low
//   busy                  high in ACCUM and DONE
module dbns_to_binary
  import dbns_pkg::*;
#(
  parameter int STORE_W = STORE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STORE_W-1:0] store000,
  input  logic [STORE_W-1:0] store001,
  input  logic [STORE_W-1:0] store010,
  input  logic [STORE_W-1:0] store100,
  input  logic [STORE_W-1:0] store101,
  input  logic [STORE_W-1:0] store110,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_value,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [STORE_W-1:0] store_q [NUM_TERMS];
  logic [STORE_W-1:0] digit;
  logic [OUT_W-1:0]   term;
  logic               capture;

  assign capture = (state_q == IDLE) && in_valid;

  // NOTE: the captured digits are pure data qualified by the FSM, so they
  // carry no reset; only control state and the accumulator are reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      store_q[0] <= store000;
      store_q[1] <= store001;
      store_q[2] <= store010;
      store_q[3] <= store100;
      store_q[4] <= store101;
      store_q[5] <= store110;
    end
  end

  always_comb begin
    digit = '0;
    for (int k = 0; k < NUM_TERMS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit = store_q[k];
      end
    end
  end

  dbns_term_mult #(
    .STORE_W (STORE_W),
    .OUT_W   (OUT_W)
  ) u_term_mult (
    .idx_i     (idx_q),
    .digit_i   (digit),
    .product_o (term)
  );

  // State register. Reset wins over any handshake on the same edge.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic.
  // NOTE: every output gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    out_value = out_valid ? acc_q : '0;
  end

endmodule

// File: tb/tb_dbns_to_binary.sv
// Self-checking bench for dbns_to_binary. Expected values come from an
// independent weighted-sum model (2^A * 3^BC per digit) pushed into a
// scoreboard queue at capture and popped when the DUT hands a result over.
module tb_dbns_to_binary;

  localparam int STORE_W = 4;
  localparam int OUT_W   = 10;

  typedef logic [STORE_W-1:0] bundle_t [6];

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  bundle_t            st;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_value;
  logic               busy;

  int                 checks = 0;
  int                 errors = 0;
  int                 cyc    = 0;
  bit                 mon_en = 1'b0;
  logic [OUT_W-1:0]   sb [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dbns_to_binary #(
    .STORE_W (STORE_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .store000  (st[0]),
    .store001  (st[1]),
    .store010  (st[2]),
    .store100  (st[3]),
    .store101  (st[4]),
    .store110  (st[5]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Digit codes ABC in term order; weight = 2^A * 3^(BC).
  function automatic logic [OUT_W-1:0] ref_sum(input bundle_t s);
    int codes [6] = '{0, 1, 2, 4, 5, 6};
    int sum = 0;
    for (int k = 0; k < 6; k++) begin
      int w = 1 << (codes[k] >> 2);
      for (int j = 0; j < (codes[k] & 3); j++) w = w * 3;
      sum += int'(s[k]) * w;
    end
    return OUT_W'(sum);
  endfunction

  // Result monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (!out_valid) begin
        check("value_zero_when_invalid", out_value, 0);
      end else if (out_ready) begin
        check("pop_avail", sb.size() != 0, 1);
        if (sb.size() != 0) check("result", out_value, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("ready_timeout", in_ready, 1);
  endtask

  task automatic capture(input bundle_t s);
    wait_ready();
    st       = s;
    in_valid = 1'b1;
    sb.push_back(ref_sum(s));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) st[k] = STORE_W'($urandom);
    check("busy_after_capture", busy, 1);
    check("in_ready_after_capture", in_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 30);
    check("latency", n, 6);
  endtask

  task automatic run_bundle(input bundle_t s);
    capture(s);
    wait_done();
    tick();
    check("idle_after_accept", in_ready, 1);
  endtask

  initial begin
    bundle_t          hs;
    logic [OUT_W-1:0] hold_exp;
    int               cap_cyc [5];
    int               n;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    st        = '{default: '0};
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Directed conversions.
    run_bundle('{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});       // 0
    run_bundle('{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});       // 1
    run_bundle('{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2});       // 42
    run_bundle('{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}); // 585
    run_bundle('{4'd3, 4'd2, 4'd1, 4'd4, 4'd0, 4'd5});       // 116
    for (int r = 0; r < 4; r++) begin
      bundle_t rs;
      for (int k = 0; k < 6; k++) rs[k] = STORE_W'($urandom);
      run_bundle(rs);
    end

    // Back-pressure: hold DONE for 20 cycles while in_valid is asserted.
    out_ready = 1'b0;
    hs = '{4'd7, 4'd9, 4'd2, 4'd11, 4'd5, 4'd13};
    hold_exp = ref_sum(hs);
    capture(hs);
    wait_done();
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      for (int k = 0; k < 6; k++) st[k] = STORE_W'($urandom);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_value", out_value, hold_exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Reset in the third ACCUM cycle, also asserting in_valid (reset wins).
    capture('{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5});
    tick();
    tick();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    tick();
    sb.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_value", out_value, 0);
    tick();
    check("rst_beats_in_valid", busy, 0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    run_bundle('{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12});

    // Back-to-back captures with in_valid held high.
    in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        tick();
        n++;
      end
      check("b2b_ready", in_ready, 1);
      for (int k = 0; k < 6; k++) st[k] = STORE_W'($urandom);
      sb.push_back(ref_sum(st));
      tick();
      cap_cyc[b] = cyc;
      for (int k = 0; k < 6; k++) st[k] = STORE_W'($urandom);
      if (b > 0) check("b2b_period", cap_cyc[b] - cap_cyc[b-1], 8);
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
